// File: rtl/ucode_sequencer.sv
// ucode_sequencer
//   Instruction decoder / microcode sequencer sitting between the prefetch
//   queue and the execution unit (XU). A 32-bit command is accepted, its
//   operand fields and opcode are latched, the opcode is looked up in an
//   external jump ROM to find the micro-entry point, and micro-ops are then
//   fetched from an external uop ROM and streamed to the XU over a
//   valid/ready handshake. Micro-branches, flush and a runaway watchdog are
//   supported.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd    command handshake from the prefetch queue
//   jrom_addr/jrom_data        jump ROM: address = registered opcode
//   urom_addr/urom_data        uop ROM: address = micro-instruction pointer
//   cond                       XU branch condition, used on a uop handshake
//   flush                      abandon the current sequence
//   uop_valid/uop_ready/uop    micro-op handshake to the XU
//   regsrc/regdst/aluop/opimm  decoded fields, held for the whole sequence
//   busy                       sequencer is not idle
//   err                        one-cycle pulse on watchdog abort
module ucode_sequencer #(
    parameter int UOP_W    = 16,
    parameter int UIP_W    = 8,
    parameter int EOS_BIT  = 4,
    parameter int BR_BIT   = 5,
    parameter int MAX_UOPS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd,
    output logic [7:0]       jrom_addr,
    input  logic [UIP_W-1:0] jrom_data,
    output logic [UIP_W-1:0] urom_addr,
    input  logic [UOP_W-1:0] urom_data,
    input  logic             cond,
    input  logic             flush,
    output logic             uop_valid,
    input  logic             uop_ready,
    output logic [UOP_W-1:0] uop,
    output logic [3:0]       regsrc,
    output logic [3:0]       regdst,
    output logic [3:0]       aluop,
    output logic [15:0]      opimm,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_JMP,
        S_LOAD,
        S_FETCH,
        S_ISSUE
    } state_t;

    localparam logic [15:0] MAX_CNT = 16'(MAX_UOPS);

    state_t           state;
    logic [7:0]       opcode;
    logic [UIP_W-1:0] uip;
    logic [15:0]      count;

    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  dec_opcode;
    logic [15:0] count_next;
    logic        wd_expire;

    assign b0 = cmd[31:24];
    assign b1 = cmd[23:16];

    // Opcode packing depends on the format nibble: the 1100 group gives up
    // b0[2] to keep two bits of b1, the 11xx groups take b1's top bits.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        dec_opcode = {b0[7:4], b0[1:0], b1[1:0]};
        case (b0[7:4])
            4'hC:             dec_opcode = {b0[7:3], 1'b0, b1[1:0]};
            4'hD, 4'hE, 4'hF: dec_opcode = {b0[7:2], b1[7:6]};
            default:          dec_opcode = {b0[7:4], b0[1:0], b1[1:0]};
        endcase
    end

    assign count_next = count + 16'd1;
    assign wd_expire  = (count_next == MAX_CNT);

    assign cmd_ready = (state == S_IDLE) && !rst && !flush;
    assign busy      = (state != S_IDLE);
    assign jrom_addr = opcode;
    assign urom_addr = uip;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            uop_valid <= 1'b0;
            uop       <= '0;
            uip       <= '0;
            opcode    <= '0;
            regsrc    <= '0;
            regdst    <= '0;
            aluop     <= '0;
            opimm     <= '0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            err <= 1'b0;
            if (flush) begin
                // A uop taken in the flush cycle still counts as consumed,
                // but the pointer and decoded fields are left untouched.
                if (state == S_ISSUE && uop_ready)
                    count <= count_next;
                state     <= S_IDLE;
                uop_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            regsrc <= {b0[3], b1[7:5]};
                            regdst <= {b0[2], b1[4:2]};
                            aluop  <= b0[7:4];
                            opimm  <= cmd[15:0];
                            opcode <= dec_opcode;
                            count  <= '0;
                            state  <= S_JMP;
                        end
                    end
                    // Jump ROM sees the new opcode during this cycle.
                    S_JMP: state <= S_LOAD;
                    S_LOAD: begin
                        uip   <= jrom_data;
                        state <= S_FETCH;
                    end
                    S_FETCH: begin
                        uop       <= urom_data;
                        uop_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        if (uop_ready) begin
                            count     <= count_next;
                            uop_valid <= 1'b0;
                            if (uop[EOS_BIT]) begin
                                state <= S_IDLE;
                            end else if (wd_expire) begin
                                err   <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                if (uop[BR_BIT] && cond)
                                    uip <= uop[UIP_W-1:0];
                                else
                                    uip <= uip + 1'b1;
                                state <= S_FETCH;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer
//   Directed bench for ucode_sequencer. The jump ROM is modelled as a
//   registered read (data one cycle after the address), the uop ROM as an
//   asynchronous read of the uip register. A transaction-level model predicts
//   the handshake timing from the latency rules and walks the ROM contents
//   to predict every issued uop; one negedge process compares the DUT to it
//   every cycle. Directed literals pin the model to hand-computed values.
module tb_ucode_sequencer;

    localparam int MAXU = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd;
    logic [7:0]  jrom_addr;
    logic [7:0]  jrom_data;
    logic [7:0]  urom_addr;
    logic [15:0] urom_data;
    logic        cond;
    logic        flush;
    logic        uop_valid;
    logic        uop_ready;
    logic [15:0] uop;
    logic [3:0]  regsrc, regdst, aluop;
    logic [15:0] opimm;
    logic        busy, err;

    logic [7:0]  jrom_mem [256];
    logic [15:0] urom_mem [256];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    ucode_sequencer #(
        .UOP_W(16), .UIP_W(8), .EOS_BIT(4), .BR_BIT(5), .MAX_UOPS(MAXU)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .jrom_addr(jrom_addr), .jrom_data(jrom_data),
        .urom_addr(urom_addr), .urom_data(urom_data),
        .cond(cond), .flush(flush),
        .uop_valid(uop_valid), .uop_ready(uop_ready), .uop(uop),
        .regsrc(regsrc), .regdst(regdst), .aluop(aluop), .opimm(opimm),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) jrom_data <= jrom_mem[jrom_addr];
    assign urom_data = urom_mem[urom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_opcode(input logic [31:0] c);
        logic [7:0] h0, h1;
        h0 = c[31:24];
        h1 = c[23:16];
        if (h0[7:4] == 4'b1100)  return {h0[7:3], 1'b0, h1[1:0]};
        else if (h0[7:6] == 2'b11) return {h0[7:2], h1[7:6]};
        else                       return {h0[7:4], h0[1:0], h1[1:0]};
    endfunction

    bit          m_active = 1'b0;
    int          m_issue_at = 0;
    int          m_err_at = -10;
    int          m_count = 0;
    logic [7:0]  m_uip = '0;
    logic [7:0]  m_opcode = '0;
    logic [3:0]  m_regsrc = '0, m_regdst = '0, m_aluop = '0;
    logic [15:0] m_opimm = '0;

    always @(negedge clk) begin : model_cmp
        bit         exp_valid;
        logic [15:0] u;
        exp_valid = m_active && (cyc >= m_issue_at);
        if (chk_en) begin
            check("uop_valid", uop_valid, exp_valid);
            check("busy", busy, m_active);
            check("cmd_ready", cmd_ready, !m_active && !rst && !flush);
            check("err", err, cyc == m_err_at);
            check("jrom_addr", jrom_addr, m_opcode);
            check("fields", {regsrc, regdst, aluop, opimm},
                  {m_regsrc, m_regdst, m_aluop, m_opimm});
            if (exp_valid) begin
                check("urom_addr", urom_addr, m_uip);
                check("uop", uop, urom_mem[m_uip]);
            end
        end
        // Predict the effect of this cycle's inputs on the next cycles.
        if (rst) begin
            m_active = 1'b0; m_uip = '0; m_opcode = '0;
            m_regsrc = '0; m_regdst = '0; m_aluop = '0; m_opimm = '0;
        end else if (flush) begin
            if (exp_valid && uop_ready) m_count++;
            m_active = 1'b0;
        end else if (!m_active && cmd_valid) begin
            m_opcode   = model_opcode(cmd);
            m_regsrc   = {cmd[27], cmd[23:21]};
            m_regdst   = {cmd[26], cmd[20:18]};
            m_aluop    = cmd[31:28];
            m_opimm    = cmd[15:0];
            m_uip      = jrom_mem[m_opcode];
            m_count    = 0;
            m_active   = 1'b1;
            m_issue_at = cyc + 4;
        end else if (exp_valid && uop_ready) begin
            u = urom_mem[m_uip];
            m_count++;
            if (u[4]) begin
                m_active = 1'b0;
            end else if (m_count == MAXU) begin
                m_active = 1'b0;
                m_err_at = cyc + 1;
            end else begin
                m_uip      = (u[5] && cond) ? u[7:0] : m_uip + 8'd1;
                m_issue_at = cyc + 2;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] c, output int t);
        bit done;
        done = 1'b0;
        t = -1;
        cmd = c;
        cmd_valid = 1'b1;
        #1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (cmd_ready) begin
                t = cyc;
                done = 1'b1;
            end
            tick();
        end
        cmd_valid = 1'b0;
        if (!done) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int tv);
        bit seen;
        seen = 1'b0;
        tv = -1;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (uop_valid) begin
                tv = cyc;
                seen = 1'b1;
            end else begin
                tick();
            end
        end
        if (!seen) check("uop_valid_timeout", 0, 1);
    endtask

    task automatic consume(input logic c, output int k);
        k = cyc;
        uop_ready = 1'b1;
        cond = c;
        tick();
        uop_ready = 1'b0;
        cond = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t, tv, k;
        for (int i = 0; i < 256; i++) begin
            jrom_mem[i] = 8'h20;
            urom_mem[i] = 16'h0010;
        end
        jrom_mem[8'h18] = 8'h20;  // cmd 1234_5678 -> single EOS uop
        jrom_mem[8'hC3] = 8'h50;  // three-uop sequence
        jrom_mem[8'hE7] = 8'h30;  // micro-branch
        jrom_mem[8'h20] = 8'hFF;  // pointer wrap
        jrom_mem[8'h36] = 8'h60;  // endless sequence
        urom_mem[8'h50] = 16'h1100;
        urom_mem[8'h51] = 16'h1201;
        urom_mem[8'h52] = 16'h1312;
        urom_mem[8'h30] = 16'h0025;
        urom_mem[8'h25] = 16'h7710;
        urom_mem[8'h31] = 16'h8810;
        urom_mem[8'hFF] = 16'h0000;
        urom_mem[8'h00] = 16'h0010;
        for (int i = 0; i < 16; i++) urom_mem[8'h60 + i] = 16'h0A00 | 16'(i);

        rst = 1'b1; cmd_valid = 1'b0; cmd = '0; cond = 1'b0;
        flush = 1'b0; uop_ready = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_uop_valid", uop_valid, 0);
        check("rst_uop", uop, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        check("idle_cmd_ready", cmd_ready, 1);

        // Basic single-uop command.
        send_cmd(32'h1234_5678, t);
        wait_valid(tv);
        check("latency_accept", tv - t, 4);
        check("t1_uop", uop, 16'h0010);
        check("t1_jrom_addr", jrom_addr, 8'h18);
        check("t1_regsrc", regsrc, 4'h1);
        check("t1_regdst", regdst, 4'h5);
        check("t1_aluop", aluop, 4'h1);
        check("t1_opimm", opimm, 16'h5678);
        consume(1'b0, k);
        check("t1_busy_after", busy, 0);

        // Three-uop sequence with a stalled second uop.
        send_cmd(32'hC503_0000, t);
        check("opc_C3", jrom_addr, 8'hC3);
        wait_valid(tv);
        check("seq_addr0", urom_addr, 8'h50);
        check("seq_uop0", uop, 16'h1100);
        consume(1'b0, k);
        wait_valid(tv);
        check("latency_consume", tv - k, 2);
        check("seq_addr1", urom_addr, 8'h51);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", uop_valid, 1);
            check("stall_uop", uop, 16'h1201);
        end
        consume(1'b0, k);
        wait_valid(tv);
        check("seq_addr2", urom_addr, 8'h52);
        check("seq_uop2", uop, 16'h1312);
        consume(1'b0, k);

        // Micro-branch taken and not taken.
        send_cmd(32'hE6C0_0000, t);
        check("opc_E7", jrom_addr, 8'hE7);
        wait_valid(tv);
        check("br_uop", uop, 16'h0025);
        consume(1'b1, k);
        wait_valid(tv);
        check("br_taken_addr", urom_addr, 8'h25);
        consume(1'b0, k);
        send_cmd(32'hE6C0_0000, t);
        wait_valid(tv);
        consume(1'b0, k);
        wait_valid(tv);
        check("br_not_taken_addr", urom_addr, 8'h31);
        consume(1'b0, k);

        // Pointer wrap from 0xFF.
        send_cmd(32'h2000_0000, t);
        wait_valid(tv);
        check("wrap_addr_ff", urom_addr, 8'hFF);
        consume(1'b0, k);
        wait_valid(tv);
        check("wrap_addr_00", urom_addr, 8'h00);
        consume(1'b0, k);

        // Watchdog on an endless sequence.
        send_cmd(32'h3102_0000, t);
        check("opc_36", jrom_addr, 8'h36);
        for (int i = 0; i < MAXU - 1; i++) begin
            wait_valid(tv);
            consume(1'b0, k);
            check("wd_no_err", err, 0);
        end
        wait_valid(tv);
        consume(1'b0, k);
        check("wd_err", err, 1);
        check("wd_idle", busy, 0);
        check("wd_cmd_ready", cmd_ready, 1);
        tick();
        check("wd_err_pulse", err, 0);

        // Flush while a uop is presented.
        send_cmd(32'h1234_5678, t);
        wait_valid(tv);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_issue_valid", uop_valid, 0);
        check("flush_issue_busy", busy, 0);
        check("flush_keeps_opcode", jrom_addr, 8'h18);

        // Flush during the jump ROM load.
        send_cmd(32'hC503_0000, t);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_load_busy", busy, 0);
        repeat (6) tick();
        check("flush_load_quiet", uop_valid, 0);
        send_cmd(32'h1234_5678, t);
        wait_valid(tv);
        check("post_flush_latency", tv - t, 4);
        check("post_flush_uop", uop, 16'h0010);
        consume(1'b0, k);

        // Reset in the middle of a fetch.
        send_cmd(32'hE6C0_0000, t);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_valid", uop_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_opcode", jrom_addr, 8'h00);
        check("rst_mid_opimm", opimm, 16'h0000);
        send_cmd(32'h2000_0000, t);
        wait_valid(tv);
        check("post_rst_addr", urom_addr, 8'hFF);
        check("post_rst_uop", uop, 16'h0000);
        consume(1'b0, k);
        wait_valid(tv);
        consume(1'b0, k);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
